vga_text_ctrl: RTL
==================

VGA_TEXT_CTRL -- requirements
Module: vga_text_ctrl

Interface
REQ-001 SHALL provide parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL provide parameters H_FP/H_SYNC/H_BP, 16/96/48, horizontal porch and sync lengths in pixels.
REQ-003 SHALL provide parameters V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical equivalents in lines.
REQ-004 SHALL provide parameters CHAR_W/CHAR_H, 9/16, character cell size in pixels.
REQ-005 SHALL provide parameter SYNC_POL, 0, sync asserted level (0 = active-low).
REQ-006 SHALL provide ports: pclk in 1, pixel clock; reset in 1, synchronous active-high reset.
REQ-007 SHALL provide ports: pix_bit in 1, font-ROM pixel for the address issued the previous cycle.
REQ-008 SHALL provide ports: h_addr/v_addr out 10 each, active pixel coordinates; col out 7, row out 5, text cell; cx out 4, cy out 4, pixel offset in cell.
REQ-009 SHALL provide ports: hsync, vsync, valid out 1 each; vga_r/vga_g/vga_b out 8 each; frame_start out 1.

Function
REQ-010 hcnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params), wrapping to 0; vcnt SHALL increment when hcnt wraps, counting 0..V_TOTAL-1 and wrapping to 0.
REQ-011 Region order per line SHALL be active, front porch, sync, back porch; likewise per frame.
REQ-012 Stage-0 outputs h_addr, v_addr, col, row, cx, cy SHALL be combinational from the counters; h_addr=hcnt and v_addr=vcnt inside active, else 0.
REQ-013 cx SHALL reset to 0 at hcnt=0 and increment per active pixel, wrapping CHAR_W-1->0 with col+1; col SHALL be 0 at hcnt=0; a trailing partial cell (640/9 -> col 71) SHALL be produced normally.
REQ-014 cy/row SHALL follow the same rule per active line, advancing at end of line; both SHALL be 0 at vcnt=0.
REQ-015 Outside the active region col, row, cx, cy SHALL read 0.
REQ-016 Stage-1 (registered, one cycle later) SHALL drive hsync, vsync, valid and RGB so they align with pix_bit.
REQ-017 hsync SHALL equal SYNC_POL when delayed hcnt lies in the sync region, else ~SYNC_POL; vsync likewise on vcnt.
REQ-018 RGB SHALL be 8'hFF on all channels when delayed valid and effective pixel=1, else 8'h00; blanking SHALL force 0.
REQ-019 frame_start SHALL pulse exactly one cycle, registered, when hcnt=0 and vcnt=0.
REQ-020 All arithmetic SHALL be 10-bit unsigned; no parameter combination SHALL exceed H_TOTAL or V_TOTAL of 1023.

Reset
REQ-021 reset SHALL set hcnt, vcnt, cx, cy, col, row to 0 synchronously.
REQ-022 On reset, stage-1 outputs SHALL become valid=0, RGB=0, frame_start=0, hsync=vsync=~SYNC_POL.
REQ-023 Reset asserted mid-line SHALL take effect on the next pclk edge and restart the frame at (0,0), with frame_start asserted on the first cycle after reset releases.

Configuration
REQ-024 Macro VGA_TEXT_CURSOR_EN SHALL compile in a blinking underline cursor with inputs cur_col[6:0] and cur_row[4:0].
REQ-025 With the macro, a 5-bit frame counter SHALL toggle blink every 32 frames; effective pixel = pix_bit XOR (blink & col==cur_col & row==cur_row & cy>=CHAR_H-2), evaluated at stage 0 and registered.
REQ-026 With the macro, blink SHALL reset to 0 (cursor hidden).
REQ-027 Without the macro, cur_col and cur_row ports SHALL be absent and effective pixel = pix_bit.

Verification
REQ-028 Reset, then run 800x525 cycles -> frame_start pulses exactly once per 420000 cycles; hsync low (SYNC_POL=0) on 96 consecutive cycles per line.
REQ-029 Check hcnt=0..8 on active line 0 -> cx 0..8, col=0; at hcnt=9 -> cx=0, col=1; at hcnt=639 -> col=71, cx=0.
REQ-030 Check vcnt=16, hcnt=0 -> row=1, cy=0; vcnt=479 -> row=29, cy=15; vcnt=480 -> row=0, valid=0.
REQ-031 Drive pix_bit=1 constantly -> RGB=FF exactly when registered valid=1, with a one-cycle lag behind h_addr entering the active region.
REQ-032 Assert reset at hcnt=300, vcnt=200 for one cycle -> next cycle counters at 0, valid=0, RGB=0; frame_start pulses on the first cycle after release.
REQ-033 With VGA_TEXT_CURSOR_EN, set cur_col=3, cur_row=2, pix_bit=0 -> frames 32..63 show FF at cy 14..15 of cell (3,2) only; frames 0..31 show none.

Source files
------------

// File: rtl/vga_text_ctrl.sv
// VGA timing generator with text-cell addressing and a one-cycle font-ROM pixel stage.
// Optional blinking underline cursor is compiled in with `define VGA_TEXT_CURSOR_EN.
`timescale 1ns/1ps
module vga_text_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CHAR_W   = 9,
    parameter int CHAR_H   = 16,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       pix_bit,
`ifdef VGA_TEXT_CURSOR_EN
    input  logic [6:0] cur_col,
    input  logic [4:0] cur_row,
`endif
    output logic [9:0] h_addr,
    output logic [9:0] v_addr,
    output logic [6:0] col,
    output logic [4:0] row,
    output logic [3:0] cx,
    output logic [3:0] cy,
    output logic       hsync,
    output logic       vsync,
    output logic       valid,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_timing
        $error("vga_text_ctrl: H_TOTAL and V_TOTAL must not exceed 1023");
    end

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [3:0] CX_LAST = 4'(CHAR_W - 1);
    localparam logic [3:0] CY_LAST = 4'(CHAR_H - 1);

    logic [9:0] r_hcnt, r_vcnt;
    logic [3:0] r_cx, r_cy;
    logic [6:0] r_col;
    logic [4:0] r_row;
    logic       r_hsync, r_vsync, r_valid, r_frame_start;

    logic w_h_last, w_v_last, w_h_act, w_v_act, w_active;
    logic w_hs_region, w_vs_region, w_cur_hit, w_pix_on;

    assign w_h_last    = (r_hcnt == H_LAST);
    assign w_v_last    = (r_vcnt == V_LAST);
    assign w_h_act     = (r_hcnt < H_ACT);
    assign w_v_act     = (r_vcnt < V_ACT);
    assign w_active    = w_h_act && w_v_act;
    assign w_hs_region = (r_hcnt >= H_SS) && (r_hcnt < H_SE);
    assign w_vs_region = (r_vcnt >= V_SS) && (r_vcnt < V_SE);

    // NOTE: reset is synchronous, so it appears only inside the clocked branch, never in the sensitivity list.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
            r_cx   <= '0;
            r_cy   <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (w_h_last) begin
            r_hcnt <= '0;
            r_cx   <= '0;
            r_col  <= '0;
            if (w_v_last) begin
                r_vcnt <= '0;
                r_cy   <= '0;
                r_row  <= '0;
            end else begin
                r_vcnt <= r_vcnt + 10'd1;
                if (w_v_act) begin
                    if (r_cy == CY_LAST) begin
                        r_cy  <= '0;
                        r_row <= r_row + 5'd1;
                    end else begin
                        r_cy <= r_cy + 4'd1;
                    end
                end
            end
        end else begin
            r_hcnt <= r_hcnt + 10'd1;
            if (w_h_act) begin
                if (r_cx == CX_LAST) begin
                    r_cx  <= '0;
                    r_col <= r_col + 7'd1;
                end else begin
                    r_cx <= r_cx + 4'd1;
                end
            end
        end
    end

    assign h_addr = w_active ? r_hcnt : 10'd0;
    assign v_addr = w_active ? r_vcnt : 10'd0;
    assign col    = w_active ? r_col  : 7'd0;
    assign row    = w_active ? r_row  : 5'd0;
    assign cx     = w_active ? r_cx   : 4'd0;
    assign cy     = w_active ? r_cy   : 4'd0;

`ifdef VGA_TEXT_CURSOR_EN
    logic [4:0] r_frame_cnt;
    logic       r_blink, r_cur_hit;

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_blink     <= 1'b0;
            r_cur_hit   <= 1'b0;
        end else begin
            if (w_h_last && w_v_last) begin
                r_frame_cnt <= r_frame_cnt + 5'd1;
                if (r_frame_cnt == 5'd31) r_blink <= ~r_blink;
            end
            r_cur_hit <= r_blink && w_active && (col == cur_col) && (row == cur_row)
                         && (cy >= 4'(CHAR_H - 2));
        end
    end
    assign w_cur_hit = r_cur_hit;
`else
    assign w_cur_hit = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_valid       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_hs_region ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vs_region ? SYNC_POL : ~SYNC_POL;
            r_valid       <= w_active;
            r_frame_start <= (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
        end
    end

    // pix_bit already belongs to the stage-1 pixel, so colour is gated by the registered valid.
    assign w_pix_on    = r_valid && (pix_bit ^ w_cur_hit);
    assign vga_r       = {8{w_pix_on}};
    assign vga_g       = {8{w_pix_on}};
    assign vga_b       = {8{w_pix_on}};
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign valid       = r_valid;
    assign frame_start = r_frame_start;

endmodule
